// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared word width, feeder state encoding and sample-pair type
package fir_pkg;

  // Default width of filter input and golden output words.
  localparam int DATA_W = 32;

  // Feeder control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_e;

  // One stored sample: filter input and its matching golden output.
  typedef struct packed {
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] gold;
  } sample_pair_t;

endpackage

// File: rtl/fir_sample_ram.sv
// rtl/fir_sample_ram.sv - sample-pair storage, one write port, one registered-address read port
module fir_sample_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are never reset; the controller's count says what is valid.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    raddr_q;

  // Store a pair at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Capture the read address; data follows from the array the next cycle.
  always_ff @(posedge clk) begin
    if (re) begin
      raddr_q <= raddr;
    end
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - buffers sample pairs, then replays them to an FIR/SSE wrapper on request
module fir_sample_feeder #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = fir_pkg::DATA_W,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_in,
  input  logic [DATA_W-1:0] wr_gold,
  output logic              wr_full,
  output logic [CW-1:0]     count,
  input  logic              start,
  input  logic              next,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] gold_data,
  output logic              stop,
  output logic              busy,
  output logic              underrun
);

  import fir_pkg::ST_IDLE;
  import fir_pkg::ST_STREAM;
  import fir_pkg::ST_DONE;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_STREAM = ST_STREAM;
  localparam logic [1:0] S_DONE   = ST_DONE;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          stop_q, stop_d;
  logic          underrun_q, underrun_d;
  logic          full_q;
  // Set once a pair has been loaded onto the read port; gates the outputs to
  // zero after reset/clear since the storage itself is not reset.
  logic          valid_q, valid_d;

  logic                ram_we;
  logic                ram_re;
  logic [AW-1:0]       ram_raddr;
  logic [2*DATA_W-1:0] ram_rdata;
  logic                last_pair;

  assign last_pair = (CW'(rd_ptr_q) == (count_q - CW'(1)));

  // Next-state logic: clear first, then the per-state rules.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    stop_d     = stop_q;
    underrun_d = underrun_q;
    valid_d    = valid_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = '0;
    if (clr) begin
      state_d    = S_IDLE;
      count_d    = '0;
      rd_ptr_d   = '0;
      stop_d     = 1'b0;
      underrun_d = 1'b0;
      valid_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (next) begin
            underrun_d = 1'b1;
          end
          // start wins over a same-cycle write; the write is dropped.
          if (start && (count_q != '0)) begin
            state_d   = S_STREAM;
            rd_ptr_d  = '0;
            ram_re    = 1'b1;
            ram_raddr = '0;
            valid_d   = 1'b1;
          end else if (wr_en && (count_q != FULL_COUNT)) begin
            ram_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        S_STREAM: begin
          if (next) begin
            if (last_pair) begin
              state_d = S_DONE;
              stop_d  = 1'b1;
            end else begin
              rd_ptr_d  = rd_ptr_q + AW'(1);
              ram_re    = 1'b1;
              ram_raddr = rd_ptr_q + AW'(1);
            end
          end
        end
        S_DONE: begin
          if (next) begin
            underrun_d = 1'b1;
          end
          if (start) begin
            state_d   = S_STREAM;
            stop_d    = 1'b0;
            rd_ptr_d  = '0;
            ram_re    = 1'b1;
            ram_raddr = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control registers with synchronous reset taking priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      stop_q     <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      stop_q     <= stop_d;
      underrun_q <= underrun_d;
      full_q     <= (count_d == FULL_COUNT);
      valid_q    <= valid_d;
    end
  end

  fir_sample_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we & ~rst),
    .waddr (count_q[AW-1:0]),
    .wdata ({wr_in, wr_gold}),
    .re    (ram_re & ~rst),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign in_data   = valid_q ? ram_rdata[2*DATA_W-1:DATA_W] : '0;
  assign gold_data = valid_q ? ram_rdata[DATA_W-1:0] : '0;
  assign stop      = stop_q;
  assign busy      = (state_q == S_STREAM);
  assign underrun  = underrun_q;
  assign count     = count_q;
  assign wr_full   = full_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - self-checking bench for fir_sample_feeder
module tb_fir_sample_feeder;

  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, clr, wr_en, start, next;
  logic [DW-1:0] wr_in, wr_gold;
  logic          wr_full, stop, busy, underrun;
  logic [CW-1:0] count;
  logic [DW-1:0] in_data, gold_data;

  always #5 clk = ~clk;

  fir_sample_feeder #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_in(wr_in), .wr_gold(wr_gold),
    .wr_full(wr_full), .count(count), .start(start), .next(next),
    .in_data(in_data), .gold_data(gold_data), .stop(stop), .busy(busy), .underrun(underrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: stored pairs as queues, replay position, visible outputs.
  int            m_mode;  // 0 idle, 1 streaming, 2 finished
  logic [DW-1:0] q_in[$];
  logic [DW-1:0] q_gold[$];
  int            m_pos;
  logic [DW-1:0] m_in, m_gold;
  bit            m_stop, m_under;

  logic [DW-1:0] seen_a[$];
  logic [DW-1:0] seen_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_pair(input int idx);
    m_in   = q_in[idx];
    m_gold = q_gold[idx];
  endtask

  task automatic model_step();
    if (rst || clr) begin
      m_mode = 0; q_in.delete(); q_gold.delete(); m_pos = 0;
      m_in = '0; m_gold = '0; m_stop = 0; m_under = 0;
    end else if (m_mode == 0) begin
      if (next) m_under = 1;
      if (start && q_in.size() > 0) begin
        m_mode = 1; m_pos = 0; load_pair(0);
      end else if (wr_en && q_in.size() < DEPTH) begin
        q_in.push_back(wr_in); q_gold.push_back(wr_gold);
      end
    end else if (m_mode == 1) begin
      if (next) begin
        if (m_pos < q_in.size() - 1) begin
          m_pos++; load_pair(m_pos);
        end else begin
          m_mode = 2; m_stop = 1;
        end
      end
    end else begin
      if (next) m_under = 1;
      if (start) begin
        m_mode = 1; m_pos = 0; m_stop = 0; load_pair(0);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic w, input logic [DW-1:0] wi,
                     input logic [DW-1:0] wg, input logic s, input logic n);
    rst = r; clr = c; wr_en = w; wr_in = wi; wr_gold = wg; start = s; next = n;
    model_step();
    @(posedge clk);
    #1;
    chk("in_data",   64'(in_data),   64'(m_in));
    chk("gold_data", 64'(gold_data), 64'(m_gold));
    chk("stop",      64'(stop),      64'(m_stop));
    chk("busy",      64'(busy),      64'(m_mode == 1));
    chk("underrun",  64'(underrun),  64'(m_under));
    chk("count",     64'(count),     64'(q_in.size()));
    chk("wr_full",   64'(wr_full),   64'(q_in.size() == DEPTH));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, '0, '0, 0, 0);
  endtask
  task automatic wr(input logic [DW-1:0] a, input logic [DW-1:0] b);
    cyc(0, 0, 1, a, b, 0, 0);
  endtask
  task automatic st();  cyc(0, 0, 0, '0, '0, 1, 0); endtask
  task automatic nx();  cyc(0, 0, 0, '0, '0, 0, 1); endtask
  task automatic rs();  cyc(1, 0, 0, '0, '0, 0, 0); endtask
  task automatic cl();  cyc(0, 1, 0, '0, '0, 0, 0); endtask

  initial begin
    rst = 1; clr = 0; wr_en = 0; wr_in = '0; wr_gold = '0; start = 0; next = 0;
    m_mode = 0; m_pos = 0; m_in = '0; m_gold = '0; m_stop = 0; m_under = 0;

    // Reset state
    rs(); rs();
    chk("rst_in_data", 64'(in_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // Three-pair stream with next every 3 cycles
    wr(1, 10); wr(2, 20); wr(3, 30);
    st();
    chk("s3_p0_in", 64'(in_data), 64'd1);
    chk("s3_p0_gold", 64'(gold_data), 64'd10);
    chk("s3_busy", 64'(busy), 64'd1);
    idle(2); nx();
    chk("s3_p1_in", 64'(in_data), 64'd2);
    chk("s3_p1_gold", 64'(gold_data), 64'd20);
    idle(2); nx();
    chk("s3_p2_in", 64'(in_data), 64'd3);
    chk("s3_p2_gold", 64'(gold_data), 64'd30);
    idle(2); nx();
    chk("s3_stop", 64'(stop), 64'd1);
    chk("s3_busy_low", 64'(busy), 64'd0);
    chk("s3_hold_in", 64'(in_data), 64'd3);
    idle(2);

    // start on an empty buffer, then next -> sticky underrun
    cl(); st();
    chk("empty_busy", 64'(busy), 64'd0);
    nx();
    chk("underrun_set", 64'(underrun), 64'd1);
    idle(3);
    chk("underrun_sticky", 64'(underrun), 64'd1);
    cl();
    chk("underrun_clr", 64'(underrun), 64'd0);

    // Fill to capacity plus one extra write, replay with next held high
    for (int i = 0; i < DEPTH; i++) wr($urandom, $urandom);
    wr(32'hDEAD_BEEF, 32'hFEED_FACE);
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_flag", 64'(wr_full), 64'd1);
    st();
    for (int i = 0; i < DEPTH; i++) begin
      nx();
      chk("no_65th", 64'(in_data == 32'hDEAD_BEEF), 64'd0);
    end
    chk("full_stop", 64'(stop), 64'd1);
    idle(1);

    // Five pairs to DONE, restart, identical replay
    cl();
    for (int i = 0; i < 5; i++) wr($urandom, $urandom);
    st();
    seen_a.delete(); seen_b.delete();
    seen_a.push_back(in_data);
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 2)); nx();
      if (i < 4) seen_a.push_back(in_data);
    end
    chk("r5_stop", 64'(stop), 64'd1);
    st();
    chk("r5_stop_drop", 64'(stop), 64'd0);
    chk("r5_p0_again", 64'(in_data), 64'(seen_a[0]));
    seen_b.push_back(in_data);
    for (int i = 0; i < 5; i++) begin
      nx();
      if (i < 4) seen_b.push_back(in_data);
    end
    for (int i = 0; i < 5; i++) chk("r5_replay", 64'(seen_b[i]), 64'(seen_a[i]));

    // Reset in the middle of a four-pair stream; clr beats start
    cl();
    for (int i = 0; i < 4; i++) wr($urandom | 1, $urandom | 1);
    st(); nx(); nx();
    rs();
    chk("mid_rst_in", 64'(in_data), 64'd0);
    chk("mid_rst_gold", 64'(gold_data), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    wr(5, 50); wr(6, 60);
    cyc(0, 1, 0, '0, '0, 1, 0);
    chk("clr_start_busy", 64'(busy), 64'd0);
    chk("clr_start_count", 64'(count), 64'd0);

    // 44 ramp pairs to a downstream consumer with irregular next spacing
    for (int k = 0; k < 44; k++) wr(DW'(k), DW'(k + 1000));
    st();
    seen_a.delete();
    seen_a.push_back(in_data);
    for (int k = 0; k < 44; k++) begin
      idle($urandom_range(0, 2)); nx();
      if (k < 43) seen_a.push_back(in_data);
      else chk("ramp_stop", 64'(stop), 64'd1);
    end
    for (int k = 0; k < 44; k++) chk("ramp_order", 64'(seen_a[k]), 64'(k));

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom % 60) == 0, ($urandom % 45) == 0, ($urandom % 2) == 0, $urandom, $urandom,
          ($urandom % 10) == 0, ($urandom % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning sample-pair buffer capacity (power of two, 2..256).
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of filter input and golden output words.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clr  input  1  empties the buffer and returns to IDLE.
REQ-006 SHALL have port wr_en  input  1  write strobe for one sample pair.
REQ-007 SHALL have port wr_in  input  DATA_W  filter input sample to store.
REQ-008 SHALL have port wr_gold  input  DATA_W  matching golden output to store.
REQ-009 SHALL have port wr_full  output  1  buffer holds DEPTH pairs.
REQ-010 SHALL have port count  output  clog2(DEPTH+1)  number of stored pairs.
REQ-011 SHALL have port start  input  1  begin streaming stored pairs.
REQ-012 SHALL have port next  input  1  one-cycle request from the downstream FIR/SSE wrapper for the next sample.
REQ-013 SHALL have port in_data  output  DATA_W  current filter input (drives the wrapper's in).
REQ-014 SHALL have port gold_data  output  DATA_W  current golden output (drives the wrapper's out_gold).
REQ-015 SHALL have port stop  output  1  stream exhausted (drives the wrapper's stop).
REQ-016 SHALL have port busy  output  1  high in STREAM.
REQ-017 SHALL have port underrun  output  1  sticky: next received while not streaming.

Function
REQ-018 SHALL implement states IDLE, STREAM, DONE.
REQ-019 IDLE: wr_en with count<DEPTH SHALL store the pair at index count and increment count; wr_en at count==DEPTH SHALL be ignored.
REQ-020 wr_en in STREAM or DONE SHALL be ignored; wr_full SHALL equal (count==DEPTH), registered.
REQ-021 IDLE, start with count>0: SHALL enter STREAM, set rd_ptr=0, load pair 0 onto in_data/gold_data on the same edge, so they are valid the cycle busy first reads 1.
REQ-022 start with count==0 SHALL be ignored; start and wr_en in the same IDLE cycle: start wins, the write is dropped.
REQ-023 STREAM, next with rd_ptr<count-1: SHALL increment rd_ptr and present the new pair the cycle after next (1-cycle latency, registered outputs).
REQ-024 STREAM, next with rd_ptr==count-1: SHALL hold in_data/gold_data, assert stop the following cycle, enter DONE.
REQ-025 DONE: stop SHALL stay 1, outputs hold last pair; start SHALL restart streaming from pair 0 with stop cleared the same edge; buffer contents preserved.
REQ-026 next in IDLE or DONE SHALL set underrun; underrun clears only on rst or clr.
REQ-027 clr in any state SHALL, next edge: IDLE, count=0, rd_ptr=0, stop=0, underrun=0; clr has priority over start, next and wr_en.
REQ-028 Data words SHALL pass unmodified; no arithmetic on data paths; rd_ptr and count widths SHALL not wrap (guarded by REQ-019/024).
REQ-029 next held high multiple cycles SHALL advance once per cycle.

Reset
REQ-030 rst SHALL force IDLE, count=0, rd_ptr=0, in_data=0, gold_data=0, stop=0, busy=0, underrun=0, wr_full=0; rst has priority over clr.
REQ-031 Buffer storage SHALL NOT be reset; rst mid-STREAM SHALL abandon the stream with count=0.

Structure
REQ-032 Shared package fir_pkg SHALL hold DATA_W, the feeder state enum, and the sample-pair struct {in, gold}.
REQ-033 Storage SHALL be one sub-module fir_sample_ram (single write port, single registered-address read port, DEPTH x 2*DATA_W).
REQ-034 Control (FSM, pointers, flags) SHALL live in fir_sample_feeder.

Verification
REQ-035 Load pairs (1,10),(2,20),(3,30), start, next every 3 cycles -> in_data/gold_data 1/10, 2/20, 3/30; stop high 1 cycle after third next; busy low.
REQ-036 Load 64 pairs plus one extra wr_en -> count=64, wr_full=1, 65th pair absent on replay.
REQ-037 start with count=0 -> remains IDLE, busy=0; then next -> underrun=1 until clr.
REQ-038 Stream 5 pairs to DONE, pulse start -> stop drops, pair 0 reappears, full replay identical.
REQ-039 rst asserted after 2nd next of a 4-pair stream -> all outputs 0, count=0 next cycle; clr with simultaneous start -> IDLE.
REQ-040 Connect to the FIR/SSE wrapper with 44 ramp pairs -> wrapper sees all 44 in order, stop rises after last next.
